logo_motion_ctrl: RTL and testbench
===================================

LOGO_MOTION_CTRL -- requirements
Module: logo_motion_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, visible lines per frame.
REQ-003 SHALL have parameter LOGO_W, default 64, logo width in pixels.
REQ-004 SHALL have parameter LOGO_H, default 64, logo height in pixels.
REQ-005 SHALL have port clk  input  1  single design clock; all state on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-008 SHALL have port run  input  1  1 = animate, 0 = freeze position.
REQ-009 SHALL have port speed  input  2  step size per frame = speed+1 pixels (1..4).
REQ-010 SHALL have port logo_x  output  10  left edge of logo, registered.
REQ-011 SHALL have port logo_y  output  10  top edge of logo, registered.
REQ-012 SHALL have port color_idx  output  3  palette index for logo colour, registered.
REQ-013 SHALL have port bounce  output  1  one-cycle pulse when an edge was hit this frame.
REQ-014 SHALL have port busy  output  1  high while FSM is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, MOVE_X, MOVE_Y, RECOLOR, each non-IDLE state lasting exactly one cycle.
REQ-016 SHALL transition IDLE->MOVE_X on frame_start=1 and run=1; otherwise remain IDLE.
REQ-017 SHALL latch step = speed+1 on the IDLE->MOVE_X edge; speed changes mid-update have no effect.
REQ-018 SHALL hold internal direction bits dir_x, dir_y (1 = increasing) and hit flags hit_x, hit_y, cleared on entry to MOVE_X.
REQ-019 In MOVE_X with dir_x=1: if logo_x+step >= H_RES-LOGO_W then logo_x = H_RES-LOGO_W, dir_x=0, hit_x=1; else logo_x += step.
REQ-020 In MOVE_X with dir_x=0: if logo_x <= step then logo_x = 0, dir_x=1, hit_x=1; else logo_x -= step.
REQ-021 MOVE_Y SHALL apply REQ-019/020 to logo_y, dir_y, hit_y using V_RES-LOGO_H.
REQ-022 Arithmetic SHALL use 11-bit intermediates so no wrap-around occurs; logo_x never exceeds H_RES-LOGO_W, logo_y never exceeds V_RES-LOGO_H.
REQ-023 In RECOLOR: if hit_x or hit_y then color_idx increments by exactly 1 (7 wraps to 0) and bounce=1 for that cycle; a corner hit (both) counts once.
REQ-024 RECOLOR SHALL always return to IDLE; full update latency frame_start->final outputs = 3 cycles.
REQ-025 frame_start arriving while busy=1 SHALL be ignored (not queued).
REQ-026 run=0 SHALL freeze logo_x, logo_y, color_idx, dir bits; an update already in progress completes.
REQ-027 bounce SHALL be 0 in every state except RECOLOR with a hit.
REQ-028 busy SHALL be 1 exactly in MOVE_X, MOVE_Y, RECOLOR.

Reset
REQ-029 While rst_n=0, SHALL force state IDLE, logo_x=0, logo_y=0, color_idx=0, dir_x=1, dir_y=1, hit flags 0, bounce=0, busy=0, step=1.
REQ-030 Reset asserted mid-update SHALL abort immediately to REQ-029 values; no partial update survives.
REQ-031 After rst_n deasserts, first update SHALL require a fresh frame_start.

Structure
REQ-032 State encoding typedef and default geometry constants (640, 480, 64, 64) SHALL live in shared package logo_pkg.
REQ-033 Per-axis bounce step SHALL be one sub-module, logo_axis_step, instantiated twice (X, Y), combinational, parameterised by axis limit.
REQ-034 Block SHALL be instantiated inside the top-level screensaver, fed by the VGA timing generator's frame_start, driving the logo renderer.

Verification
REQ-035 Reset, run=1, speed=0, 1 frame_start -> after 3 cycles logo_x=1, logo_y=1, color_idx=0, bounce never high.
REQ-036 Preload logo_x=574, dir_x=1, speed=3 (step 4), frame_start -> logo_x=576, dir_x=0, color_idx+1, bounce pulse exactly 1 cycle.
REQ-037 Position (576,416), dirs 1/1, step 1 -> corner hit: logo_x=576, logo_y=416, both dirs flip, color_idx increments by 1 only.
REQ-038 frame_start pulses at cycles 0 and 1 -> only one update; frame_start with run=0 -> outputs unchanged, busy stays 0.
REQ-039 Assert rst_n=0 during MOVE_Y -> all outputs equal reset values in same cycle; color_idx 7 + hit -> 0.

Source files
------------

// File: rtl/logo_pkg.sv
// Shared definitions for the bouncing-logo motion controller: FSM state
// encoding, default screen/logo geometry and datapath widths.
package logo_pkg;

    // Default geometry: 640x480 visible area with a 64x64 logo
    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_LOGO_W = 64;
    localparam int DEF_LOGO_H = 64;

    // Position registers, wide intermediates that cannot wrap, step and palette widths
    localparam int POS_W   = 10;
    localparam int CALC_W  = 11;
    localparam int STEP_W  = 3;
    localparam int COLOR_W = 3;

    // One frame update walks MOVE_X -> MOVE_Y -> RECOLOR and back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE_X  = 2'd1,
        ST_MOVE_Y  = 2'd2,
        ST_RECOLOR = 2'd3
    } state_e;

endpackage

// File: rtl/logo_axis_step.sv
// Combinational bounce step for one axis: advances the position by 'step'
// in the current direction, clamping to [0, LIMIT] and flipping direction
// whenever a wall is reached.
module logo_axis_step
    import logo_pkg::*;
#(
    parameter int LIMIT = DEF_H_RES - DEF_LOGO_W
) (
    input  logic [POS_W-1:0]  pos_in,
    input  logic              dir_in,
    input  logic [STEP_W-1:0] step,
    output logic [POS_W-1:0]  pos_out,
    output logic              dir_out,
    output logic              hit
);

    localparam logic [CALC_W-1:0] LIMIT_C = CALC_W'(LIMIT);

    logic [CALC_W-1:0] pos_ext;
    logic [CALC_W-1:0] step_ext;
    logic [CALC_W-1:0] sum;

    assign pos_ext  = {1'b0, pos_in};
    assign step_ext = CALC_W'(step);
    assign sum      = pos_ext + step_ext;

    // Wall test is done on the widened values so a large position plus step never wraps
    always_comb begin
        pos_out = pos_in;
        dir_out = dir_in;
        hit     = 1'b0;
        if (dir_in) begin
            if (sum >= LIMIT_C) begin
                pos_out = POS_W'(LIMIT);
                dir_out = 1'b0;
                hit     = 1'b1;
            end else begin
                pos_out = sum[POS_W-1:0];
            end
        end else begin
            if (pos_ext <= step_ext) begin
                pos_out = '0;
                dir_out = 1'b1;
                hit     = 1'b1;
            end else begin
                pos_out = POS_W'(pos_ext - step_ext);
            end
        end
    end

endmodule

// File: rtl/logo_motion_ctrl.sv
// Bouncing-logo motion controller. Once per frame (frame_start with run=1)
// it moves the logo one step in X, then in Y, then changes the palette
// index if either wall was hit. All outputs come straight from flops.
module logo_motion_ctrl
    import logo_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int LOGO_W = DEF_LOGO_W,
    parameter int LOGO_H = DEF_LOGO_H
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic               run,
    input  logic [1:0]         speed,
    output logic [POS_W-1:0]   logo_x,
    output logic [POS_W-1:0]   logo_y,
    output logic [COLOR_W-1:0] color_idx,
    output logic               bounce,
    output logic               busy
);

    localparam int X_MAX = H_RES - LOGO_W;
    localparam int Y_MAX = V_RES - LOGO_H;

    state_e              state_q,  state_d;
    logic [STEP_W-1:0]   step_q,   step_d;
    logic [POS_W-1:0]    logo_x_q, logo_x_d;
    logic [POS_W-1:0]    logo_y_q, logo_y_d;
    logic [COLOR_W-1:0]  color_idx_q, color_idx_d;
    logic                dir_x_q,  dir_x_d;
    logic                dir_y_q,  dir_y_d;
    logic                hit_x_q,  hit_x_d;
    logic                hit_y_q,  hit_y_d;
    logic                bounce_q, bounce_d;
    logic                busy_q,   busy_d;

    logic [POS_W-1:0]    x_next, y_next;
    logic                x_dir_next, y_dir_next;
    logic                x_hit, y_hit;

    logo_axis_step #(.LIMIT(X_MAX)) u_step_x (
        .pos_in  (logo_x_q),
        .dir_in  (dir_x_q),
        .step    (step_q),
        .pos_out (x_next),
        .dir_out (x_dir_next),
        .hit     (x_hit)
    );

    logo_axis_step #(.LIMIT(Y_MAX)) u_step_y (
        .pos_in  (logo_y_q),
        .dir_in  (dir_y_q),
        .step    (step_q),
        .pos_out (y_next),
        .dir_out (y_dir_next),
        .hit     (y_hit)
    );

    // Next-state logic; bounce is raised on entry to RECOLOR so it is high for exactly that cycle
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        logo_x_d    = logo_x_q;
        logo_y_d    = logo_y_q;
        color_idx_d = color_idx_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        hit_x_d     = hit_x_q;
        hit_y_d     = hit_y_q;
        bounce_d    = 1'b0;
        busy_d      = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (frame_start && run) begin
                    state_d = ST_MOVE_X;
                    step_d  = STEP_W'({1'b0, speed}) + STEP_W'(1);
                    hit_x_d = 1'b0;
                    hit_y_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_MOVE_X: begin
                logo_x_d = x_next;
                dir_x_d  = x_dir_next;
                hit_x_d  = x_hit;
                state_d  = ST_MOVE_Y;
                busy_d   = 1'b1;
            end
            ST_MOVE_Y: begin
                logo_y_d = y_next;
                dir_y_d  = y_dir_next;
                hit_y_d  = y_hit;
                bounce_d = hit_x_q | y_hit;
                state_d  = ST_RECOLOR;
                busy_d   = 1'b1;
            end
            ST_RECOLOR: begin
                if (hit_x_q || hit_y_q) begin
                    color_idx_d = color_idx_q + COLOR_W'(1);
                end
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Single state register for the FSM and all registered outputs; reset aborts any update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= STEP_W'(1);
            logo_x_q    <= '0;
            logo_y_q    <= '0;
            color_idx_q <= '0;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            hit_x_q     <= 1'b0;
            hit_y_q     <= 1'b0;
            bounce_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            logo_x_q    <= logo_x_d;
            logo_y_q    <= logo_y_d;
            color_idx_q <= color_idx_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
            bounce_q    <= bounce_d;
            busy_q      <= busy_d;
        end
    end

    assign logo_x    = logo_x_q;
    assign logo_y    = logo_y_q;
    assign color_idx = color_idx_q;
    assign bounce    = bounce_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Self-checking bench for logo_motion_ctrl: a behavioural model predicts each
// frame update, pushes it to a scoreboard queue, and the entry is popped and
// compared when the controller drops busy.
module tb_logo_motion_ctrl;

    localparam int XMAX = 640 - 64;
    localparam int YMAX = 480 - 64;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       run;
    logic [1:0] speed;
    logic [9:0] logo_x;
    logic [9:0] logo_y;
    logic [2:0] color_idx;
    logic       bounce;
    logic       busy;

    typedef struct {
        int x;
        int y;
        int c;
        bit b;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int mx, my, mc;
    bit mdx, mdy;

    logo_motion_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .run         (run),
        .speed       (speed),
        .logo_x      (logo_x),
        .logo_y      (logo_y),
        .color_idx   (color_idx),
        .bounce      (bounce),
        .busy        (busy)
    );

    // Free-running clock, active edge is posedge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global guard so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        mx = 0; my = 0; mc = 0; mdx = 1'b1; mdy = 1'b1;
    endtask

    // One frame of the model: move X, move Y, recolor once if anything hit
    task automatic model_update(input int step, output bit hit_any);
        bit hx, hy;
        hx = 1'b0;
        hy = 1'b0;
        if (mdx) begin
            if (mx + step >= XMAX) begin mx = XMAX; mdx = 1'b0; hx = 1'b1; end
            else mx = mx + step;
        end else begin
            if (mx <= step) begin mx = 0; mdx = 1'b1; hx = 1'b1; end
            else mx = mx - step;
        end
        if (mdy) begin
            if (my + step >= YMAX) begin my = YMAX; mdy = 1'b0; hy = 1'b1; end
            else my = my + step;
        end else begin
            if (my <= step) begin my = 0; mdy = 1'b1; hy = 1'b1; end
            else my = my - step;
        end
        if (hx || hy) mc = (mc + 1) % 8;
        hit_any = hx | hy;
    endtask

    task automatic push_expect(input int step);
        exp_t e;
        bit   h;
        model_update(step, h);
        e.x = mx; e.y = my; e.c = mc; e.b = h;
        sb.push_back(e);
    endtask

    // Drain one scoreboard entry: sample at negedges until busy falls, then compare
    task automatic wait_update(input int first_idx, input string tag);
        int   busy_cycles;
        int   bounce_cycles;
        int   bounce_at;
        bit   done;
        exp_t e;
        busy_cycles   = 0;
        bounce_cycles = 0;
        bounce_at     = -1;
        done          = 1'b0;
        for (int i = first_idx; i <= first_idx + 8 && !done; i++) begin
            if (i > first_idx) @(negedge clk);
            if (bounce === 1'b1) begin bounce_cycles++; bounce_at = i; end
            if (busy === 1'b1) busy_cycles++;
            else done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("[TB] FAIL %s timeout: busy still high after budget, required low", tag);
        end
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL %s scoreboard empty: got 0 entries, required 1", tag);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (busy_cycles !== 4 - first_idx) begin
            n_err++;
            $display("[TB] FAIL %s busy_len: got %0d, required %0d", tag, busy_cycles, 4 - first_idx);
        end
        n_cmp++;
        if (bounce_cycles !== int'(e.b)) begin
            n_err++;
            $display("[TB] FAIL %s bounce_count: got %0d, required %0d", tag, bounce_cycles, e.b);
        end
        if (e.b) begin
            n_cmp++;
            if (bounce_at !== 3) begin
                n_err++;
                $display("[TB] FAIL %s bounce_cycle: got %0d, required 3", tag, bounce_at);
            end
        end
        n_cmp++;
        if (logo_x !== 10'(e.x)) begin
            n_err++;
            $display("[TB] FAIL %s logo_x: got %0d, required %0d", tag, logo_x, e.x);
        end
        n_cmp++;
        if (logo_y !== 10'(e.y)) begin
            n_err++;
            $display("[TB] FAIL %s logo_y: got %0d, required %0d", tag, logo_y, e.y);
        end
        n_cmp++;
        if (color_idx !== 3'(e.c)) begin
            n_err++;
            $display("[TB] FAIL %s color_idx: got %0d, required %0d", tag, color_idx, e.c);
        end
    endtask

    // Issue one frame_start pulse from an idle negedge and check the resulting update
    task automatic run_frame(input logic [1:0] spd, input string tag);
        frame_start = 1'b1;
        run         = 1'b1;
        speed       = spd;
        push_expect(int'(spd) + 1);
        @(negedge clk);
        frame_start = 1'b0;
        wait_update(1, tag);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; run = 1'b0; speed = 2'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if (logo_x !== 10'd0) begin n_err++; $display("[TB] FAIL reset logo_x: got %0d, required 0", logo_x); end
        n_cmp++; if (logo_y !== 10'd0) begin n_err++; $display("[TB] FAIL reset logo_y: got %0d, required 0", logo_y); end
        n_cmp++; if (color_idx !== 3'd0) begin n_err++; $display("[TB] FAIL reset color_idx: got %0d, required 0", color_idx); end
        n_cmp++; if (bounce !== 1'b0) begin n_err++; $display("[TB] FAIL reset bounce: got %b, required 0", bounce); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset busy: got %b, required 0", busy); end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // Speed 0 from reset: one pixel down-right, no bounce, colour unchanged
    task automatic test_basic_step();
        apply_reset();
        run_frame(2'd0, "basic");
        n_cmp++;
        if (logo_x !== 10'd1 || logo_y !== 10'd1 || color_idx !== 3'd0) begin
            n_err++;
            $display("[TB] FAIL basic_abs: got (%0d,%0d,c%0d), required (1,1,c0)", logo_x, logo_y, color_idx);
        end
    endtask

    // Walk X to 574 then take a 4-pixel step into the right wall
    task automatic test_right_edge();
        int c_before;
        apply_reset();
        for (int i = 0; i < 143; i++) run_frame(2'd3, "walk");
        run_frame(2'd1, "walk574");
        n_cmp++;
        if (logo_x !== 10'd574) begin n_err++; $display("[TB] FAIL pre_edge logo_x: got %0d, required 574", logo_x); end
        c_before = mc;
        run_frame(2'd3, "right_edge");
        n_cmp++;
        if (logo_x !== 10'd576 || color_idx !== 3'((c_before + 1) % 8)) begin
            n_err++;
            $display("[TB] FAIL right_edge_abs: got x=%0d c=%0d, required x=576 c=%0d", logo_x, color_idx, (c_before + 1) % 8);
        end
        run_frame(2'd3, "after_edge");
        n_cmp++;
        if (logo_x !== 10'd572) begin n_err++; $display("[TB] FAIL dir_x_flip: got %0d, required 572", logo_x); end
    endtask

    // Logo placed at the bottom-right corner moving down-right hits both walls in one frame
    task automatic test_corner();
        apply_reset();
        dut.logo_x_q = 10'd576;
        dut.logo_y_q = 10'd416;
        mx = 576; my = 416;
        @(negedge clk);
        run_frame(2'd0, "corner");
        n_cmp++;
        if (logo_x !== 10'd576 || logo_y !== 10'd416 || color_idx !== 3'd1) begin
            n_err++;
            $display("[TB] FAIL corner_abs: got (%0d,%0d,c%0d), required (576,416,c1)", logo_x, logo_y, color_idx);
        end
        run_frame(2'd0, "corner_next");
        n_cmp++;
        if (logo_x !== 10'd575 || logo_y !== 10'd415 || color_idx !== 3'd1) begin
            n_err++;
            $display("[TB] FAIL corner_dirs: got (%0d,%0d,c%0d), required (575,415,c1)", logo_x, logo_y, color_idx);
        end
    endtask

    // Double pulse, mid-update speed change, run=0 freeze and run drop mid-update
    task automatic test_back_to_back();
        int  px, py, pc;
        bit  saw_busy;
        apply_reset();
        frame_start = 1'b1; run = 1'b1; speed = 2'd0;
        push_expect(1);
        @(negedge clk);
        speed = 2'd3;
        @(negedge clk);
        frame_start = 1'b0;
        wait_update(2, "double_pulse");
        saw_busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        n_cmp++;
        if (saw_busy) begin n_err++; $display("[TB] FAIL second_pulse: got busy=1, required 0"); end
        n_cmp++;
        if (logo_x !== 10'd1) begin n_err++; $display("[TB] FAIL step_latch: got %0d, required 1", logo_x); end

        px = mx; py = my; pc = mc;
        run = 1'b0; frame_start = 1'b1; speed = 2'd2;
        @(negedge clk);
        frame_start = 1'b0;
        saw_busy = (busy !== 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        n_cmp++;
        if (saw_busy) begin n_err++; $display("[TB] FAIL freeze_busy: got busy=1, required 0"); end
        n_cmp++;
        if (logo_x !== 10'(px) || logo_y !== 10'(py) || color_idx !== 3'(pc)) begin
            n_err++;
            $display("[TB] FAIL freeze_pos: got (%0d,%0d,c%0d), required (%0d,%0d,c%0d)", logo_x, logo_y, color_idx, px, py, pc);
        end

        frame_start = 1'b1; run = 1'b1; speed = 2'd1;
        push_expect(2);
        @(negedge clk);
        frame_start = 1'b0; run = 1'b0;
        wait_update(1, "run_drop_mid");
    endtask

    // Reset during MOVE_Y aborts the update; later colour 7 plus a hit wraps to 0
    task automatic test_reset_mid();
        apply_reset();
        run_frame(2'd2, "pre_abort");
        frame_start = 1'b1; run = 1'b1; speed = 2'd2;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (logo_x !== 10'd0 || logo_y !== 10'd0 || color_idx !== 3'd0 || bounce !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_reset: got (%0d,%0d,c%0d,b%b,busy%b), required all 0", logo_x, logo_y, color_idx, bounce, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || logo_x !== 10'd0 || logo_y !== 10'd0) begin
            n_err++;
            $display("[TB] FAIL no_resume: got busy=%b x=%0d y=%0d, required busy=0 x=0 y=0", busy, logo_x, logo_y);
        end

        dut.logo_x_q    = 10'd576;
        dut.color_idx_q = 3'd7;
        mx = 576; mc = 7;
        @(negedge clk);
        run_frame(2'd0, "color_wrap");
        n_cmp++;
        if (color_idx !== 3'd0) begin n_err++; $display("[TB] FAIL color_wrap_abs: got %0d, required 0", color_idx); end
    endtask

    // Random speeds with idle gaps of varying length
    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            run_frame(2'($urandom_range(3, 0)), "random");
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; run = 1'b0; speed = 2'd0;
        model_reset();
        test_reset();
        test_basic_step();
        test_right_edge();
        test_corner();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
